// File: rtl/hilo_mdu.sv
// HI/LO register file with an iterative 32x32 shift-add multiplier.
// Optional macro HILO_EARLY_OUT_EN ends the multiply once the multiplier is exhausted.
module hilo_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        hilowrite,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic        neg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        accept;
    logic        is_mul;
    logic        is_signed;
    logic        wr_en;
    logic        last_step;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_step;
    logic [63:0] result;

    assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_signed = (funct == F_MULT);
    assign wr_en     = (state == IDLE) && hilowrite && !flush;
    assign mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign result    = neg ? (~acc + 64'd1) : acc;
    assign hi_o      = hi;
    assign lo_o      = lo;

`ifdef HILO_EARLY_OUT_EN
    assign last_step = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
    assign last_step = (cnt == 5'd31);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, stall and done decode
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_en && is_mul) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: begin
                stall      = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: moves to HI/LO, operand load, shift-add step, commit
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            cnt    <= 5'd0;
            neg    <= 1'b0;
        end else begin
            if (wr_en && funct == F_MTHI) hi <= a;
            if (wr_en && funct == F_MTLO) lo <= a;
            if (accept) begin
                mcand  <= {32'd0, mag_a};
                mplier <= mag_b;
                acc    <= 64'd0;
                cnt    <= 5'd0;
                neg    <= is_signed && (a[31] ^ b[31]);
            end
            if (state == MUL && !flush) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
            end
            if (state == DONE && !flush) begin
                {hi, lo} <= result;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu.
// Expected stall lengths follow HILO_EARLY_OUT_EN when defined.
module tb_hilo_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        hilowrite;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int pass_cnt = 0;
    int total = 0;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    hilo_mdu dut (
        .clk(clk), .rst(rst), .hilowrite(hilowrite), .funct(funct),
        .a(a), .b(b), .flush(flush), .stall(stall), .done(done),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Issue a multiply and hold it until stall drops; samples mid-cycle.
    task automatic mul_run(input logic [5:0] f, input logic [31:0] x,
                           input logic [31:0] y, output int sc,
                           output int dc, output bit tmo);
        logic d;
        hilowrite = 1'b1; funct = f; a = x; b = y;
        sc = 0; dc = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #3;
            if (!stall) begin
                tmo = 1'b0;
                break;
            end
            sc++;
            d = done;
            if (d) dc++;
            @(posedge clk); #1;
            if (d) hilowrite = 1'b0;
        end
        hilowrite = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hilowrite = 1'b0; funct = 6'd0;
        a = 32'd0; b = 32'd0; flush = 1'b0;
        next_cycle(); next_cycle();
        rst = 1'b0;
        #3;
        total++; if (hi_o !== 32'h0) $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); else pass_cnt++;
        total++; if (lo_o !== 32'h0) $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_mthi_mtlo();
        hilowrite = 1'b1; funct = F_MTHI; a = 32'h12345678;
        #3;
        total++; if (stall !== 1'b0) $display("FAIL mthi_stall got=%b exp=0", stall); else pass_cnt++;
        next_cycle();
        funct = F_MTLO; a = 32'hCAFEF00D;
        #3;
        total++; if (hi_o !== 32'h12345678) $display("FAIL mthi_hi got=%h exp=%h", hi_o, 32'h12345678); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL mtlo_stall got=%b exp=0", stall); else pass_cnt++;
        next_cycle();
        hilowrite = 1'b0;
        #3;
        total++; if (lo_o !== 32'hCAFEF00D) $display("FAIL mtlo_lo got=%h exp=%h", lo_o, 32'hCAFEF00D); else pass_cnt++;
        total++; if (hi_o !== 32'h12345678) $display("FAIL mtlo_hi_keep got=%h exp=%h", hi_o, 32'h12345678); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_multu_max();
        int sc, dc; bit tmo;
        mul_run(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, sc, dc, tmo);
        total++; if (tmo) $display("FAIL multu_max_timeout got=timeout exp=stall_drop"); else pass_cnt++;
        total++; if (hi_o !== 32'hFFFFFFFE) $display("FAIL multu_max_hi got=%h exp=%h", hi_o, 32'hFFFFFFFE); else pass_cnt++;
        total++; if (lo_o !== 32'h00000001) $display("FAIL multu_max_lo got=%h exp=%h", lo_o, 32'h1); else pass_cnt++;
        total++; if (sc != 34) $display("FAIL multu_max_stall got=%0d exp=34", sc); else pass_cnt++;
        total++; if (dc != 1) $display("FAIL multu_max_done got=%0d exp=1", dc); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_mult_signed();
        int sc, dc; bit tmo;
        int exp_sc;
        mul_run(F_MULT, 32'hFFFFFFFD, 32'h5, sc, dc, tmo);
`ifdef HILO_EARLY_OUT_EN
        exp_sc = 5;
`else
        exp_sc = 34;
`endif
        total++; if (tmo) $display("FAIL mult_neg3x5_timeout got=timeout exp=stall_drop"); else pass_cnt++;
        total++; if (hi_o !== 32'hFFFFFFFF) $display("FAIL mult_neg3x5_hi got=%h exp=%h", hi_o, 32'hFFFFFFFF); else pass_cnt++;
        total++; if (lo_o !== 32'hFFFFFFF1) $display("FAIL mult_neg3x5_lo got=%h exp=%h", lo_o, 32'hFFFFFFF1); else pass_cnt++;
        total++; if (sc != exp_sc) $display("FAIL mult_neg3x5_stall got=%0d exp=%0d", sc, exp_sc); else pass_cnt++;
        next_cycle();
        mul_run(F_MULT, 32'h80000000, 32'hFFFFFFFF, sc, dc, tmo);
`ifdef HILO_EARLY_OUT_EN
        exp_sc = 3;
`else
        exp_sc = 34;
`endif
        total++; if (tmo) $display("FAIL mult_min_timeout got=timeout exp=stall_drop"); else pass_cnt++;
        total++; if (hi_o !== 32'h00000000) $display("FAIL mult_min_hi got=%h exp=%h", hi_o, 32'h0); else pass_cnt++;
        total++; if (lo_o !== 32'h80000000) $display("FAIL mult_min_lo got=%h exp=%h", lo_o, 32'h80000000); else pass_cnt++;
        total++; if (sc != exp_sc) $display("FAIL mult_min_stall got=%0d exp=%0d", sc, exp_sc); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_flush();
        int n_mul;
        int dc = 0;
        hilowrite = 1'b1; funct = F_MTHI; a = 32'hAAAAAAAA;
        next_cycle();
        funct = F_MTLO;
        next_cycle();
        funct = F_MULTU; a = 32'd3; b = 32'd4;
`ifdef HILO_EARLY_OUT_EN
        n_mul = 2;
`else
        n_mul = 10;
`endif
        for (int i = 0; i < n_mul; i++) begin
            #3; if (done) dc++;
            next_cycle();
        end
        #3;
        total++; if (stall !== 1'b1) $display("FAIL flush_pre_stall got=%b exp=1", stall); else pass_cnt++;
        flush = 1'b1;
        #1; if (done) dc++;
        next_cycle();
        flush = 1'b0; hilowrite = 1'b0;
        #3;
        total++; if (stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            next_cycle(); #3;
        end
        total++; if (dc != 0) $display("FAIL flush_done got=%0d exp=0", dc); else pass_cnt++;
        total++; if (hi_o !== 32'hAAAAAAAA) $display("FAIL flush_hi got=%h exp=%h", hi_o, 32'hAAAAAAAA); else pass_cnt++;
        total++; if (lo_o !== 32'hAAAAAAAA) $display("FAIL flush_lo got=%h exp=%h", lo_o, 32'hAAAAAAAA); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_idle_flush();
        hilowrite = 1'b1; flush = 1'b1; funct = F_MTHI; a = 32'h55555555;
        next_cycle();
        funct = F_MULT; a = 32'd2; b = 32'd2;
        #3;
        total++; if (stall !== 1'b0) $display("FAIL idle_flush_stall got=%b exp=0", stall); else pass_cnt++;
        next_cycle();
        flush = 1'b0; hilowrite = 1'b0;
        #3;
        total++; if (hi_o !== 32'hAAAAAAAA) $display("FAIL idle_flush_hi got=%h exp=%h", hi_o, 32'hAAAAAAAA); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL idle_flush_noaccept got=%b exp=0", stall); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_early_out();
        int sc, dc; bit tmo;
        int exp_sc;
        mul_run(F_MULTU, 32'd7, 32'd2, sc, dc, tmo);
`ifdef HILO_EARLY_OUT_EN
        exp_sc = 4;
`else
        exp_sc = 34;
`endif
        total++; if (tmo) $display("FAIL early_timeout got=timeout exp=stall_drop"); else pass_cnt++;
        total++; if (hi_o !== 32'd0) $display("FAIL early_hi got=%h exp=%h", hi_o, 32'd0); else pass_cnt++;
        total++; if (lo_o !== 32'd14) $display("FAIL early_lo got=%h exp=%h", lo_o, 32'd14); else pass_cnt++;
        total++; if (sc != exp_sc) $display("FAIL early_stall got=%0d exp=%0d", sc, exp_sc); else pass_cnt++;
        total++; if (dc != 1) $display("FAIL early_done got=%0d exp=1", dc); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_mul();
        hilowrite = 1'b1; funct = F_MULTU; a = 32'hFFFFFFFF; b = 32'h3;
        next_cycle();
        next_cycle();
        rst = 1'b1; hilowrite = 1'b0;
        next_cycle();
        rst = 1'b0;
        #3;
        total++; if (hi_o !== 32'd0) $display("FAIL rst_mid_hi got=%h exp=%h", hi_o, 32'd0); else pass_cnt++;
        total++; if (lo_o !== 32'd0) $display("FAIL rst_mid_lo got=%h exp=%h", lo_o, 32'd0); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall got=%b exp=0", stall); else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_multu_max();
        test_mult_signed();
        test_flush();
        test_idle_flush();
        test_early_out();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
